// File: rtl/life_array_param.sv
// Parametrised ROWS x COLS Game of Life array (rule B3/S23) with row load/readback, wrap or tiled edges,
// auto-run timer and extinct/stable detection. Define LIFE_HALT_ON_STABLE_EN to halt auto-run on a settled pattern.
module life_array_param #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int SEL_W = 4,
    parameter int GEN_W = 16,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COLS-1:0]  vali,
    input  logic [SEL_W-1:0] vali_selector,
    input  logic             write_enb,
    input  logic [SEL_W-1:0] valo_selector,
    output logic [COLS-1:0]  valo,
    output logic [COLS-1:0]  valo_prev,
    input  logic             step,
    input  logic             run,
    input  logic [PER_W-1:0] period,
    input  logic             wrap,
    input  logic [COLS-1:0]  ni,
    input  logic [COLS-1:0]  si,
    input  logic [ROWS-1:0]  wi,
    input  logic [ROWS-1:0]  ei,
    input  logic             nwi,
    input  logic             nei,
    input  logic             sei,
    input  logic             swi,
    output logic [COLS-1:0]  no,
    output logic [COLS-1:0]  so,
    output logic [ROWS-1:0]  wo,
    output logic [ROWS-1:0]  eo,
    output logic             nwo,
    output logic             neo,
    output logic             seo,
    output logic             swo,
    output logic [GEN_W-1:0] generation,
    output logic             extinct,
    output logic             stable,
    output logic             halted
);

    logic [ROWS-1:0][COLS-1:0] state_q, state_d;
    logic [ROWS-1:0][COLS-1:0] prev_q, prev_d;
    logic [ROWS-1:0][COLS-1:0] nextState;
    logic [ROWS+1:0][COLS+1:0] pad;

    logic [COLS-1:0]  valo_q, valo_d;
    logic [COLS-1:0]  valoPrev_q, valoPrev_d;
    logic [GEN_W-1:0] genCnt_q, genCnt_d;
    logic [PER_W-1:0] perCnt_q, perCnt_d;
    logic [PER_W-1:0] perLimit;
    logic             pending_q, pending_d;
    logic             extinct_q, extinct_d;
    logic             stable_q, stable_d;
    logic             halted_q, halted_d;

    logic rawTick;
    logic tick;
    logic advReq;
    logic doAdv;
    logic writeHit;

    // Pad the array with a one-cell ring: either the opposite edge (torus) or the tiling inputs.
    always_comb begin
        pad[0] = {(wrap ? state_q[ROWS-1][0] : nei),
                  (wrap ? state_q[ROWS-1] : ni),
                  (wrap ? state_q[ROWS-1][COLS-1] : nwi)};
        pad[ROWS+1] = {(wrap ? state_q[0][0] : sei),
                       (wrap ? state_q[0] : si),
                       (wrap ? state_q[0][COLS-1] : swi)};
        for (int r = 0; r < ROWS; r++) begin
            pad[r+1] = {(wrap ? state_q[r][0] : ei[r]),
                        state_q[r],
                        (wrap ? state_q[r][COLS-1] : wi[r])};
        end
    end

    always_comb begin : nextGen
        logic [3:0] nbrCnt;
        nextState = '0;
        nbrCnt    = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                nbrCnt = '0;
                for (int dr = 0; dr < 3; dr++) begin
                    for (int dc = 0; dc < 3; dc++) begin
                        if (!(dr == 1 && dc == 1)) begin
                            nbrCnt = nbrCnt + 4'(pad[r+dr][c+dc]);
                        end
                    end
                end
                nextState[r][c] = (nbrCnt == 4'd3) || ((nbrCnt == 4'd2) && state_q[r][c]);
            end
        end
    end

    // Auto-run: a period of 0 is treated as 1, and >= keeps a shortened period from being skipped.
    assign perLimit = (period == '0) ? '0 : period - PER_W'(1);
    assign rawTick  = run && (perCnt_q >= perLimit);
    assign perCnt_d = (run && !rawTick) ? perCnt_q + PER_W'(1) : '0;

`ifdef LIFE_HALT_ON_STABLE_EN
    assign tick     = rawTick && !(stable_q || extinct_q || halted_q);
    assign halted_d = run && !writeHit && (halted_q || stable_q || extinct_q);
`else
    assign tick     = rawTick;
    assign halted_d = 1'b0;
`endif

    // A write always wins the cycle; any advance requested meanwhile waits in the pending flag.
    assign advReq    = step || tick;
    assign doAdv     = !write_enb && (advReq || pending_q);
    assign pending_d = write_enb && (advReq || pending_q);

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        writeHit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (write_enb && (vali_selector == SEL_W'(r))) begin
                state_d[r] = vali;
                writeHit   = 1'b1;
            end
        end
        if (doAdv) begin
            prev_d  = state_q;
            state_d = nextState;
        end
    end

    always_comb begin
        valo_d     = '0;
        valoPrev_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (valo_selector == SEL_W'(r)) begin
                valo_d     = state_q[r];
                valoPrev_d = prev_q[r];
            end
        end
    end

    assign genCnt_d  = doAdv ? genCnt_q + GEN_W'(1) : genCnt_q;
    assign extinct_d = (state_q == '0);
    assign stable_d  = doAdv ? (nextState == state_q) : (writeHit ? 1'b0 : stable_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= '0;
            prev_q     <= '0;
            valo_q     <= '0;
            valoPrev_q <= '0;
            genCnt_q   <= '0;
            perCnt_q   <= '0;
            pending_q  <= 1'b0;
            extinct_q  <= 1'b1;
            stable_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            valo_q     <= valo_d;
            valoPrev_q <= valoPrev_d;
            genCnt_q   <= genCnt_d;
            perCnt_q   <= perCnt_d;
            pending_q  <= pending_d;
            extinct_q  <= extinct_d;
            stable_q   <= stable_d;
            halted_q   <= halted_d;
        end
    end

    assign valo       = valo_q;
    assign valo_prev  = valoPrev_q;
    assign generation = genCnt_q;
    assign extinct    = extinct_q;
    assign stable     = stable_q;
    assign halted     = halted_q;

    // Edge outputs reflect the current generation so neighbouring tiles see a consistent snapshot.
    assign no  = state_q[0];
    assign so  = state_q[ROWS-1];
    assign nwo = state_q[0][0];
    assign neo = state_q[0][COLS-1];
    assign seo = state_q[ROWS-1][COLS-1];
    assign swo = state_q[ROWS-1][0];

    always_comb begin
        wo = '0;
        eo = '0;
        for (int r = 0; r < ROWS; r++) begin
            wo[r] = state_q[r][0];
            eo[r] = state_q[r][COLS-1];
        end
    end

endmodule

// File: tb/tb_life_array_param.sv
// Directed bench for life_array_param (16x16, 5-bit selectors so out-of-range rows are reachable).
// Expected values are queued when stimulus is applied and popped when the DUT output is sampled.
module tb_life_array_param;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int SEL_W = 5;
    localparam int GEN_W = 16;
    localparam int PER_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [COLS-1:0]  vali;
    logic [SEL_W-1:0] vali_selector;
    logic             write_enb;
    logic [SEL_W-1:0] valo_selector;
    logic [COLS-1:0]  valo, valo_prev;
    logic             step, run;
    logic [PER_W-1:0] period;
    logic             wrap;
    logic [COLS-1:0]  ni, si;
    logic [ROWS-1:0]  wi, ei;
    logic             nwi, nei, sei, swi;
    logic [COLS-1:0]  no, so;
    logic [ROWS-1:0]  wo, eo;
    logic             nwo, neo, seo, swo;
    logic [GEN_W-1:0] generation;
    logic             extinct, stable, halted;

    int vectors = 0;
    int fails   = 0;
    logic [63:0] expQ[$];

    life_array_param #(
        .ROWS(ROWS), .COLS(COLS), .SEL_W(SEL_W), .GEN_W(GEN_W), .PER_W(PER_W)
    ) dut (
        .clk(clk), .reset(reset),
        .vali(vali), .vali_selector(vali_selector), .write_enb(write_enb),
        .valo_selector(valo_selector), .valo(valo), .valo_prev(valo_prev),
        .step(step), .run(run), .period(period), .wrap(wrap),
        .ni(ni), .si(si), .wi(wi), .ei(ei),
        .nwi(nwi), .nei(nei), .sei(sei), .swi(swi),
        .no(no), .so(so), .wo(wo), .eo(eo),
        .nwo(nwo), .neo(neo), .seo(seo), .swo(swo),
        .generation(generation), .extinct(extinct), .stable(stable), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [SEL_W-1:0] sel,
                                 input logic [COLS-1:0] data, input logic stp);
        write_enb     = we;
        vali_selector = sel;
        vali          = data;
        step          = stp;
        cycle();
        write_enb = 1'b0;
        step      = 1'b0;
    endtask

    task automatic pushExpected(input logic [63:0] v);
        expQ.push_back(v);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs);
        logic [63:0] exp;
        vectors++;
        if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h, scoreboard empty", tag, obs);
        end else begin
            exp = expQ.pop_front();
            assert (obs === exp) else begin
                fails++;
                $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    task automatic expectNow(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        pushExpected(exp);
        checkOutput(tag, obs);
    endtask

    task automatic readRow(input int r, input logic [COLS-1:0] cur, input logic [COLS-1:0] prv,
                           input string tag);
        valo_selector = SEL_W'(r);
        pushExpected(64'(cur));
        pushExpected(64'(prv));
        cycle();
        checkOutput({tag, ".cur"}, 64'(valo));
        checkOutput({tag, ".prev"}, 64'(valo_prev));
    endtask

    task automatic doReset();
        run   = 1'b0;
        step  = 1'b0;
        write_enb = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1; vali = '0; vali_selector = '0; write_enb = 1'b0; valo_selector = '0;
        step = 1'b0; run = 1'b0; period = '0; wrap = 1'b0;
        ni = '0; si = '0; wi = '0; ei = '0; nwi = 1'b0; nei = 1'b0; sei = 1'b0; swi = 1'b0;

        // Reset state
        cycle();
        expectNow("rst.valo", 64'(valo), 64'h0);
        expectNow("rst.valo_prev", 64'(valo_prev), 64'h0);
        expectNow("rst.gen", 64'(generation), 64'h0);
        expectNow("rst.extinct", 64'(extinct), 64'h1);
        expectNow("rst.stable", 64'(stable), 64'h0);
        expectNow("rst.halted", 64'(halted), 64'h0);
        reset = 1'b0;
        cycle();

        // Blinker oscillates horizontal -> vertical -> horizontal
        applyStimulus(1'b1, 5'd5, 16'h0038, 1'b0);
        cycle();
        expectNow("blink.extinct0", 64'(extinct), 64'h0);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        expectNow("blink.gen1", 64'(generation), 64'h1);
        expectNow("blink.stable1", 64'(stable), 64'h0);
        readRow(4, 16'h0010, 16'h0000, "blink.r4");
        readRow(5, 16'h0010, 16'h0038, "blink.r5");
        readRow(6, 16'h0010, 16'h0000, "blink.r6");
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        expectNow("blink.gen2", 64'(generation), 64'h2);
        expectNow("blink.stable2", 64'(stable), 64'h0);
        readRow(4, 16'h0000, 16'h0010, "blink2.r4");
        readRow(5, 16'h0038, 16'h0010, "blink2.r5");
        readRow(6, 16'h0000, 16'h0010, "blink2.r6");

        // Still-life block, then a write clears stable
        doReset();
        applyStimulus(1'b1, 5'd2, 16'h0006, 1'b0);
        applyStimulus(1'b1, 5'd3, 16'h0006, 1'b0);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        expectNow("still.stable", 64'(stable), 64'h1);
        expectNow("still.gen", 64'(generation), 64'h1);
        readRow(2, 16'h0006, 16'h0006, "still.r2");
        readRow(3, 16'h0006, 16'h0006, "still.r3");
        applyStimulus(1'b1, 5'd9, 16'h0001, 1'b0);
        expectNow("still.stableClr", 64'(stable), 64'h0);

        // Toroidal wrap: blinker straddling west/east edge; tiling inputs must be ignored
        doReset();
        wrap = 1'b1;
        ni = '1; si = '1; wi = '1; ei = '1; nwi = 1'b1; nei = 1'b1; sei = 1'b1; swi = 1'b1;
        applyStimulus(1'b1, 5'd5, 16'h8003, 1'b0);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        expectNow("wrap.wo", 64'(wo), 64'h0070);
        expectNow("wrap.eo", 64'(eo), 64'h0000);
        readRow(4, 16'h0001, 16'h0000, "wrap.r4");
        readRow(5, 16'h0001, 16'h8003, "wrap.r5");
        readRow(6, 16'h0001, 16'h0000, "wrap.r6");
        readRow(0, 16'h0000, 16'h0000, "wrap.r0");
        ni = '0; si = '0; wi = '0; ei = '0; nwi = 1'b0; nei = 1'b0; sei = 1'b0; swi = 1'b0;

        // Same pattern with zero external edges dies out; extinct lags by one cycle
        doReset();
        wrap = 1'b0;
        applyStimulus(1'b1, 5'd5, 16'h8003, 1'b0);
        cycle();
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        expectNow("edge0.extinctLag", 64'(extinct), 64'h0);
        cycle();
        expectNow("edge0.extinct", 64'(extinct), 64'h1);

        // External north neighbours give birth in row 0
        doReset();
        ni = 16'h0007;
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        expectNow("ext.no", 64'(no), 64'h0002);
        ni = 16'h0001; nwi = 1'b1; wi = 16'h0001;
        doReset();
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        readRow(0, 16'h0001, 16'h0000, "extc.r0");
        readRow(1, 16'h0000, 16'h0000, "extc.r1");
        ni = '0; nwi = 1'b0; wi = '0;

        // Edge and corner outputs from current state
        doReset();
        applyStimulus(1'b1, 5'd0, 16'h0001, 1'b0);
        applyStimulus(1'b1, 5'd15, 16'h8000, 1'b0);
        expectNow("edge.no", 64'(no), 64'h0001);
        expectNow("edge.so", 64'(so), 64'h8000);
        expectNow("edge.wo", 64'(wo), 64'h0001);
        expectNow("edge.eo", 64'(eo), 64'h8000);
        expectNow("edge.corners", 64'({nwo, neo, seo, swo}), 64'hA);

        // Write/advance collision: one deferred advance after the last write
        doReset();
        applyStimulus(1'b1, 5'd5, 16'h0038, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd0, 16'hFFFF, 1'b1);
        expectNow("coll.genHeld", 64'(generation), 64'h0);
        cycle();
        expectNow("coll.genAdv", 64'(generation), 64'h1);
        cycle();
        expectNow("coll.genOnce", 64'(generation), 64'h1);
        readRow(0, 16'h7FFE, 16'hFFFF, "coll.r0");
        readRow(1, 16'h7FFE, 16'h0000, "coll.r1");
        readRow(5, 16'h0010, 16'h0038, "coll.r5");

        // Selectors out of range; read during write returns the old row
        doReset();
        applyStimulus(1'b1, 5'd17, 16'hFFFF, 1'b0);
        cycle();
        expectNow("sel.wrIgnored", 64'(extinct), 64'h1);
        readRow(1, 16'h0000, 16'h0000, "sel.alias");
        applyStimulus(1'b1, 5'd4, 16'hAAAA, 1'b0);
        readRow(20, 16'h0000, 16'h0000, "sel.rd20");
        readRow(4, 16'hAAAA, 16'h0000, "sel.r4");
        valo_selector = 5'd3;
        applyStimulus(1'b1, 5'd3, 16'h1234, 1'b0);
        expectNow("sel.rdDuringWr", 64'(valo), 64'h0000);
        cycle();
        expectNow("sel.rdAfterWr", 64'(valo), 64'h1234);

        // Auto-run timing, period 0, then asynchronous reset mid-run
        doReset();
        applyStimulus(1'b1, 5'd5, 16'h0038, 1'b0);
        valo_selector = 5'd5;
        period = 16'd4;
        run = 1'b1;
        repeat (3) cycle();
        expectNow("auto.gen3cyc", 64'(generation), 64'h0);
        cycle();
        expectNow("auto.gen4cyc", 64'(generation), 64'h1);
        repeat (4) cycle();
        expectNow("auto.gen8cyc", 64'(generation), 64'h2);
        period = 16'd0;
        cycle();
        expectNow("auto.p0a", 64'(generation), 64'h3);
        cycle();
        expectNow("auto.p0b", 64'(generation), 64'h4);
        #2 reset = 1'b1;
        #1;
        expectNow("arst.gen", 64'(generation), 64'h0);
        expectNow("arst.valo", 64'(valo), 64'h0);
        expectNow("arst.valo_prev", 64'(valo_prev), 64'h0);
        expectNow("arst.extinct", 64'(extinct), 64'h1);
        expectNow("arst.stable", 64'(stable), 64'h0);
        expectNow("arst.halted", 64'(halted), 64'h0);
        run = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        expectNow("arst.genAfter", 64'(generation), 64'h0);

        // Auto-run on a still life
        doReset();
        applyStimulus(1'b1, 5'd2, 16'h0006, 1'b0);
        applyStimulus(1'b1, 5'd3, 16'h0006, 1'b0);
        cycle();
        period = 16'd0;
        run = 1'b1;
        repeat (5) cycle();
`ifdef LIFE_HALT_ON_STABLE_EN
        expectNow("halt.gen", 64'(generation), 64'h1);
        expectNow("halt.halted", 64'(halted), 64'h1);
        applyStimulus(1'b0, 5'd0, 16'h0000, 1'b1);
        expectNow("halt.manualStep", 64'(generation), 64'h2);
        run = 1'b0;
        cycle();
        expectNow("halt.clear", 64'(halted), 64'h0);
`else
        expectNow("norun.gen", 64'(generation), 64'h5);
        expectNow("norun.halted", 64'(halted), 64'h0);
        expectNow("norun.stable", 64'(stable), 64'h1);
        run = 1'b0;
`endif

        if (expQ.size() != 0) begin
            vectors++;
            fails++;
            $display("[TB] FAIL scoreboard.leftover: observed %0d entries, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/life_array_param.md
Name: life_array_param

Overview:
- Parametrised single-clock Game of Life array, ROWS x COLS cells, rule B3/S23. It succeeds the fixed 16x16 tiled array.
- Row-addressed load and readback, with previous-generation readback.
- Selectable toroidal wrap, or external edge/diagonal neighbours for tiling into larger arrays.
- Built-in auto-run timer, generation counter, and extinct/stable detection. Sits under the display/UART controller.

Parameters:
ROWS, 16, number of rows (>=3)
COLS, 16, number of columns (>=3)
SEL_W, 4, row selector width (2^SEL_W >= ROWS)
GEN_W, 16, generation counter width
PER_W, 16, auto-run period width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
vali  in  COLS  row write data, bit c = column c (column 0 = west)
vali_selector  in  SEL_W  row to write (row 0 = north)
write_enb  in  1  write vali into row vali_selector this cycle
valo_selector  in  SEL_W  row to read
valo  out  COLS  current-generation row, registered
valo_prev  out  COLS  previous-generation row, registered
step  in  1  single-cycle request to advance one generation
run  in  1  auto-run enable
period  in  PER_W  auto-run interval in cycles
wrap  in  1  1 = toroidal, 0 = external edges
ni, si  in  COLS  neighbours above row 0 / below row ROWS-1
wi, ei  in  ROWS  neighbours left of column 0 / right of column COLS-1
nwi, nei, sei, swi  in  1  diagonal corner neighbours
no, so  out  COLS  row 0 / row ROWS-1 current state
wo, eo  out  ROWS  column 0 / column COLS-1 current state
nwo, neo, seo, swo  out  1  corner cells (0,0), (0,COLS-1), (ROWS-1,COLS-1), (ROWS-1,0)
generation  out  GEN_W  generations since reset
extinct  out  1  all cells dead
stable  out  1  last step produced no change
halted  out  1  auto-run halted (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - state and prev cleared; valo, valo_prev, generation = 0.
  - extinct = 1; stable = 0; halted = 0.
  - pending flag and period counter cleared.
- Advance event = step, or an auto-run tick.
- On an advance event with no write in the same cycle:
  - prev <= state; state <= next(state); generation <= generation+1, wrapping modulo 2^GEN_W.
- Neighbourhood rules:
  - wrap=1: neighbours come from the opposite array edge/corner. ni/si/wi/ei and the diagonal inputs are ignored.
  - wrap=0: off-array neighbours come from the input ports.
- Edge outputs are combinational from state. They are never derived from next.
- Write:
  - When write_enb=1 and vali_selector < ROWS: state[row] <= vali; prev is untouched.
  - When vali_selector >= ROWS, the write is ignored.
- Write/advance collision:
  - Write wins. The advance is recorded in a pending flag.
  - The pending advance executes on the first later cycle with write_enb=0.
  - Further advance events while pending collapse into the single pending advance.
- Read:
  - valo/valo_prev <= row[valo_selector] each cycle, 1-cycle latency.
  - Both read 0 when valo_selector >= ROWS.
  - A read in the same cycle as a write or advance returns the pre-update row.
- Auto-run:
  - While run=1 the counter increments. On reaching max(period,1)-1 it issues a tick and clears.
  - period=0 behaves as 1, i.e. a tick every cycle.
  - run=0 clears the counter.
  - Changing period mid-count takes effect on the next compare.
- extinct is registered: equals (state == 0) with 1-cycle lag.
- stable:
  - Set on an executed advance where next == state.
  - Cleared on an executed advance with change, or on any accepted write.
- Reset mid-operation aborts any pending advance and any auto-run count.

Optional Feature:
- Macro LIFE_HALT_ON_STABLE_EN.
- Defined:
  - While run=1, auto-run ticks are suppressed once stable=1 or extinct=1, and halted=1.
  - halted clears when run drops, an accepted write occurs, or reset.
  - Manual step still advances.
- Undefined: halted tied 0; auto-run never stops on its own.

Test Plan:
- Blinker, 16x16, wrap=0, edges 0: write row5=0x0038 → step → rows4,5,6 = 0x0010, generation=1. → step → row5=0x0038, rows4/6=0, stable=0.
- Still life: write rows2,3=0x0006, step → state unchanged, stable=1, generation=1. → write row9=0x0001 → stable=0.
- Wrap: write row5=0x8003, wrap=1, step → rows4,5,6 = 0x0001. Same stimulus with wrap=0 → all rows 0, extinct=1 one cycle later.
- Collision: step with write_enb=1 (row0=0xFFFF) for 3 cycles, step repeated → exactly one advance, on the cycle after the last write; generation increments by 1.
- Auto-run: blinker loaded, run=1, period=4 → generation increments every 4 cycles. period=0 → every cycle. Reset asserted mid-run → all outputs at reset values immediately.
- Selectors: vali_selector=17 with ROWS=16 → no state change. valo_selector=20 → valo=0. With LIFE_HALT_ON_STABLE_EN, run on still life → halted=1, generation frozen at 1.
